// File: rtl/alu_share_ctrl.sv
// Shares one multi-cycle ALU between two requesters: round-robin grant, hold operands
// for EXEC_CYCLES, capture result/flags, return them to the owner under backpressure.
module alu_share_ctrl #(
    parameter int WIDTH       = 64,
    parameter int EXEC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_cntrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_cntrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic       last_grant;
    logic       owner;
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       capture;
    logic       release_rsp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant prefers the requester that was not served last, so a waiting peer never starves.
    always_comb begin
        state_next  = state;
        grant0      = 1'b0;
        grant1      = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                grant0     = req0_valid & (~req1_valid | last_grant);
                grant1     = req1_valid & (~req0_valid | ~last_grant);
                req0_ready = grant0 & ~reset;
                req1_ready = grant1 & ~reset;
                accept     = req0_ready | req1_ready;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                if (owner ? rsp1_ready : rsp0_ready) begin
                    release_rsp = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= 4'd0;
        end else begin
            if (accept) begin
                owner <= req1_ready;
                cnt   <= CNT_INIT;
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (release_rsp) begin
                last_grant <= owner;
            end
        end
    end

    // Operands stay registered through EXEC and RESP so the ALU inputs never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cntrl  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept) begin
                alu_a     <= req1_ready ? req1_a : req0_a;
                alu_b     <= req1_ready ? req1_b : req0_b;
                alu_cntrl <= req1_ready ? req1_cntrl : req0_cntrl;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: slow ALU stub, table-driven ops with a response scoreboard,
// and hand-written sequences for arbitration, backpressure and mid-op reset.
module tb_alu_share_ctrl;

    localparam int EC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_cntrl, req1_cntrl;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]  rsp_flags, alu_flags;
    logic [2:0]  alu_cntrl;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    alu_share_ctrl #(.WIDTH(64), .EXEC_CYCLES(EC)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cntrl(req0_cntrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cntrl(req1_cntrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference ALU: {result, negative, zero, overflow, carry_out}
    function automatic logic [67:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] c);
        logic [64:0] s;
        logic [63:0] r;
        logic        v, cy;
        s = '0; v = 1'b0; cy = 1'b0;
        case (c)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0]; cy = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = s[63:0]; cy = s[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a ^ b;
            default: r = a;
        endcase
        return {r, r[63], (r == 64'd0), v, cy};
    endfunction

    // ALU stub: output is garbage until its inputs have been held EC cycles.
    logic [130:0] prev_in = '0;
    int           held = 0;
    logic [67:0]  stub_ref;
    assign stub_ref   = alu_ref(alu_a, alu_b, alu_cntrl);
    assign alu_result = (held >= EC) ? stub_ref[67:4] : 64'hDEAD_BEEF_DEAD_BEEF;
    assign alu_flags  = (held >= EC) ? stub_ref[3:0] : 4'hF;
    always @(negedge clk) begin
        if ({alu_a, alu_b, alu_cntrl} !== prev_in) begin
            held    <= 1;
            prev_in <= {alu_a, alu_b, alu_cntrl};
        end else if (held < 100) begin
            held <= held + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard {owner, result, flags}: pushed on accept, popped on response handshake.
    logic [68:0] sb[$];
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (req0_valid && req0_ready) sb.push_back({1'b0, alu_ref(req0_a, req0_b, req0_cntrl)});
            if (req1_valid && req1_ready) sb.push_back({1'b1, alu_ref(req1_a, req1_b, req1_cntrl)});
            if (req0_ready && req1_ready) check("sb_two_ready", 1, 0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 1, 0);
                end else begin
                    logic [68:0] e;
                    e = sb.pop_front();
                    check("sb_owner", {63'd0, rsp1_valid}, {63'd0, e[68]});
                    check("sb_result", rsp_result, e[67:4]);
                    check("sb_flags", {60'd0, rsp_flags}, {60'd0, e[3:0]});
                end
            end
        end
    end

    typedef struct {
        bit          req;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  c;
        logic [63:0] r;
        logic [3:0]  f;
    } vec_t;
    vec_t tbl[8];

    task automatic do_op(input bit req, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] c, input logic [63:0] er, input logic [3:0] ef,
                         input string tag);
        int t;
        bit got;
        t = 0;
        @(posedge clk); #1;
        if (!req) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_cntrl = c;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_cntrl = c;
        end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req ? req1_ready : req0_ready) begin
                got = 1; t = cyc;
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        check({tag, "_accept"}, {63'd0, got}, 64'd1);
        if (!got) return;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cyc == t + 1) begin
                check({tag, "_alu_a"}, alu_a, a);
                check({tag, "_alu_b"}, alu_b, b);
                check({tag, "_alu_cntrl"}, {61'd0, alu_cntrl}, {61'd0, c});
                check({tag, "_exec_ready"}, {62'd0, req0_ready, req1_ready}, 64'd0);
            end
            if (rsp0_valid || rsp1_valid) begin
                got = 1;
                check({tag, "_latency"}, 64'(cyc - t), 64'(EC + 1));
                check({tag, "_rsp_owner"}, {62'd0, rsp1_valid, rsp0_valid},
                      req ? 64'd2 : 64'd1);
                check({tag, "_result"}, rsp_result, er);
                check({tag, "_flags"}, {60'd0, rsp_flags}, {60'd0, ef});
            end
        end
        check({tag, "_rsp_seen"}, {63'd0, got}, 64'd1);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp0_valid && !rsp1_valid) done = 1;
        end
        check({tag, "_drain"}, {63'd0, done}, 64'd1);
    endtask

    initial begin
        int          n;
        bit          got;
        int          gown[4];
        int          gcyc[4];
        logic [67:0] rr;
        logic [63:0] ra, rb;
        logic [2:0]  rc;

        tbl[0] = '{0, 64'd5, 64'd7, 3'b010, 64'd12, 4'b0000};
        tbl[1] = '{1, 64'd0, 64'd1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
        tbl[2] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000, 4'b1010};
        tbl[3] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 4'b0101};
        tbl[4] = '{0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 3'b000,
                   64'h00F0_00F0_00F0_00F0, 4'b0000};
        tbl[5] = '{1, 64'd5, 64'd5, 3'b011, 64'd0, 4'b0101};
        tbl[6] = '{0, 64'h8000_0000_0000_0000, 64'd1, 3'b011, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        tbl[7] = '{1, 64'd3, 64'd9, 3'b110, 64'd3, 4'b0000};

        reset = 1;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cntrl = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cntrl = '0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_alu", {alu_a ^ alu_b, 61'd0, alu_cntrl}, 128'd0);
        check("reset_rsp", {rsp_result[59:0], rsp_flags}, 64'd0);
        check("reset_valid_ready", {60'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 64'd0);
        @(posedge clk); #1;
        reset = 0;

        for (int i = 0; i < 8; i++)
            do_op(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].f,
                  $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 3'($urandom_range(0, 4));
            rr = alu_ref(ra, rb, rc);
            do_op(i[0], ra, rb, rc, rr[67:4], rr[3:0], $sformatf("rnd%0d", i));
        end

        // Both requesters valid back-to-back: strict alternation, one grant per EC+2 cycles.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 64'd100; req0_b = 64'd1; req0_cntrl = 3'b010;
        req1_valid = 1; req1_a = 64'd200; req1_b = 64'd2; req1_cntrl = 3'b011;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gown[n] = req1_ready ? 1 : 0; gcyc[n] = cyc; n++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        check("rr_grant_count", 64'(n), 64'd4);
        for (int i = 0; i < n; i++) check($sformatf("rr_owner%0d", i), 64'(gown[i]), 64'(i % 2));
        for (int i = 1; i < n; i++)
            check($sformatf("rr_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'(EC + 2));
        drain("rr");

        // Response backpressure on requester 1 with requester 0 waiting.
        rsp1_ready = 0;
        @(posedge clk); #1;
        req1_valid = 1; req1_a = 64'h1234; req1_b = 64'd1; req1_cntrl = 3'b010;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req1_ready) got = 1;
        end
        check("bp_accept", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        req1_valid = 0;
        req0_valid = 1; req0_a = 64'd9; req0_b = 64'd4; req0_cntrl = 3'b011;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp1_valid) got = 1;
        end
        check("bp_rsp_seen", {63'd0, got}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd2);
            check("bp_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
            check("bp_result", rsp_result, 64'h1235);
            check("bp_alu", {alu_a, alu_b ^ {61'd0, alu_cntrl}}, {64'h1234, 64'd3});
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        rsp1_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        check("bp_pending_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
        @(posedge clk); #1;
        req0_valid = 0;
        drain("bp");

        // Reset one cycle after accept abandons the op.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 64'd100; req0_b = 64'd23; req0_cntrl = 3'b010;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1;
        end
        check("rst_accept", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        req0_valid = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("rst_alu", {alu_a | alu_b, 61'd0, alu_cntrl}, 128'd0);
        check("rst_rsp", rsp_result | {60'd0, rsp_flags}, 64'd0);
        check("rst_valid_ready", {60'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 64'd0);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) got = 1;
        end
        check("rst_no_rsp", {63'd0, got}, 64'd0);

        // After reset the pointer favours requester 0 on a tie.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 64'd1; req0_b = 64'd2; req0_cntrl = 3'b001;
        req1_valid = 1; req1_a = 64'd6; req1_b = 64'd3; req1_cntrl = 3'b100;
        @(negedge clk);
        check("tie_after_reset", {62'd0, req0_ready, req1_ready}, 64'd2);
        @(posedge clk); #1;
        req0_valid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req1_ready) got = 1;
        end
        check("tie_second", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        req1_valid = 0;
        drain("tie");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
